// File: rtl/mem_stall_controller.sv
// -----------------------------------------------------------------------------
// mem_stall_controller
//
// Purpose:
//   Sequences MEM-stage memory accesses for the pipelined MIPS core. It does
//   the following:
//   - Detects data-cache read misses and write-through stores.
//   - Freezes the front of the pipeline while the access is in progress.
//   - Runs a request/acknowledge transaction with main memory.
//   - Refills the one-word cache line, then releases the pipeline for a
//     single RESUME cycle.
//   - Keeps saturating performance counters.
//   - Raises a sticky error flag when main memory never acknowledges.
//
// Parameters:
//   TIMEOUT      - maximum cycles waited for memAck in one request state
//   CNT_W        - width of the performance counters
//
// Ports:
//   clk          in   system clock, all state updates on posedge
//   reset        in   synchronous active-high reset
//   memRead      in   MEM-stage load
//   memWrite     in   MEM-stage store
//   hit          in   data-cache hit for the current MEM address
//   addr         in   MEM-stage address
//   writeData    in   MEM-stage store data
//   memAck       in   main memory completion strobe
//   memRData     in   main memory read data, valid with memAck
//   stall        out  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//   bubble       out  force RegWrite=0 into MEM/WB this cycle
//   memReq       out  main memory request
//   memWe        out  request is a write
//   memAddr      out  latched request address
//   memWData     out  latched store data
//   cacheFill    out  write fillData into the cache at memAddr
//   fillData     out  latched memRData
//   memError     out  sticky timeout flag
//   missCount    out  read misses serviced
//   writeCount   out  stores serviced
//   stallCycles  out  cycles with stall=1
// -----------------------------------------------------------------------------
module mem_stall_controller #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             hit,
  input  logic [31:0]      addr,
  input  logic [31:0]      writeData,
  input  logic             memAck,
  input  logic [31:0]      memRData,
  output logic             stall,
  output logic             bubble,
  output logic             memReq,
  output logic             memWe,
  output logic [31:0]      memAddr,
  output logic [31:0]      memWData,
  output logic             cacheFill,
  output logic [31:0]      fillData,
  output logic             memError,
  output logic [CNT_W-1:0] missCount,
  output logic [CNT_W-1:0] writeCount,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The wait counter holds the number of ack-less REQ cycles already spent.
  // Timeout is declared during the cycle that would make it TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ_REQ  = 3'd1,
    WRITE_REQ = 3'd2,
    FILL      = 3'd3,
    RESUME    = 3'd4
  } state_t;

  // Saturating increment shared by all performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       fill_data_q, fill_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              cache_fill_q, cache_fill_d;
  logic              bubble_q, bubble_d;
  logic              mem_error_q, mem_error_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]  write_cnt_q, write_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              stall_s;
  logic              busy_s;

  // Next-state, datapath latches, counters and the raw stall decode.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_data_d = fill_data_q;
    mem_error_d = mem_error_q;
    miss_cnt_d  = miss_cnt_q;
    write_cnt_d = write_cnt_q;
    bubble_d    = 1'b0;
    stall_s     = 1'b0;

    case (state_q)
      IDLE: begin
        // A load miss wins over a simultaneous store. The store is dropped.
        if (memRead && !hit) begin
          stall_s    = 1'b1;
          mem_addr_d = addr;
          wait_d     = '0;
          state_d    = READ_REQ;
        end else if (memWrite) begin
          stall_s     = 1'b1;
          mem_addr_d  = addr;
          mem_wdata_d = writeData;
          wait_d      = '0;
          state_d     = WRITE_REQ;
        end else begin
          stall_s = 1'b0;
        end
      end
      READ_REQ: begin
        stall_s = 1'b1;
        if (memAck) begin
          fill_data_d = memRData;
          miss_cnt_d  = sat_inc(miss_cnt_q);
          state_d     = FILL;
        end else if (wait_q == WAIT_LAST) begin
          mem_error_d = 1'b1;
          bubble_d    = 1'b1;
          state_d     = RESUME;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WRITE_REQ: begin
        stall_s = 1'b1;
        if (memAck) begin
          write_cnt_d = sat_inc(write_cnt_q);
          state_d     = RESUME;
        end else if (wait_q == WAIT_LAST) begin
          mem_error_d = 1'b1;
          bubble_d    = 1'b1;
          state_d     = RESUME;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      FILL: begin
        stall_s = 1'b1;
        state_d = RESUME;
      end
      RESUME: begin
        // The pipeline advances on this edge. The MEM-stage inputs still
        // describe the finished access, so they are deliberately not looked at.
        stall_s = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall_s = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (stall_s) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    // Memory-side strobes are decoded from the next state so they are
    // registered, glitch-free, and aligned with the state they belong to.
    mem_req_d    = (state_d == READ_REQ) || (state_d == WRITE_REQ);
    mem_we_d     = (state_d == WRITE_REQ);
    cache_fill_d = (state_d == FILL);
  end

  // Busy states hold stall high from the register, independent of inputs.
  assign busy_s = (state_q == READ_REQ) || (state_q == WRITE_REQ) ||
                  (state_q == FILL);

  // While reset is asserted, only the combinational IDLE detect may raise stall.
  assign stall = reset ? (stall_s & ~busy_s) : stall_s;

  // State register and all output/datapath flops, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      fill_data_q  <= 32'h0000_0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      cache_fill_q <= 1'b0;
      bubble_q     <= 1'b0;
      mem_error_q  <= 1'b0;
      miss_cnt_q   <= '0;
      write_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_data_q  <= fill_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      cache_fill_q <= cache_fill_d;
      bubble_q     <= bubble_d;
      mem_error_q  <= mem_error_d;
      miss_cnt_q   <= miss_cnt_d;
      write_cnt_q  <= write_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble      = bubble_q;
  assign memReq      = mem_req_q;
  assign memWe       = mem_we_q;
  assign memAddr     = mem_addr_q;
  assign memWData    = mem_wdata_q;
  assign cacheFill   = cache_fill_q;
  assign fillData    = fill_data_q;
  assign memError    = mem_error_q;
  assign missCount   = miss_cnt_q;
  assign writeCount  = write_cnt_q;
  assign stallCycles = stall_cnt_q;

endmodule

// File: doc/mem_stall_controller.md
# mem_stall_controller

Sequences MEM-stage memory accesses for the pipelined MIPS core. It detects data-cache read misses and write-through stores, freezes the pipeline, runs a request/acknowledge transaction with main memory, and refills the one-word cache line. It then releases the pipeline so the MEM/WB pipeline register captures a valid `hit` and read data. It also keeps performance counters and flags memory timeouts.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles spent waiting for `memAck` in one request state.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  input  1  system clock; all state updates on posedge.
- `reset`  input  1  reset, synchronous and active-high.
- `memRead`  input  1  MEM-stage load (from EX/MEM register).
- `memWrite`  input  1  MEM-stage store.
- `hit`  input  1  data-cache hit for current MEM address (combinational).
- `addr`  input  32  MEM-stage address (ALU result).
- `writeData`  input  32  MEM-stage store data.
- `memAck`  input  1  main memory completion strobe.
- `memRData`  input  32  main memory read data; valid with `memAck`.
- `stall`  output  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational).
- `bubble`  output  1  force RegWrite=0 into MEM/WB this cycle.
- `memReq`  output  1  main memory request.
- `memWe`  output  1  request is a write.
- `memAddr`  output  32  latched request address.
- `memWData`  output  32  latched store data.
- `cacheFill`  output  1  write `fillData` into cache at `memAddr`.
- `fillData`  output  32  latched `memRData`.
- `memError`  output  1  sticky timeout flag.
- `missCount`  output  CNT_W  read misses serviced.
- `writeCount`  output  CNT_W  stores serviced.
- `stallCycles`  output  CNT_W  cycles with `stall`=1.

## Operation
- FSM states: IDLE, READ_REQ, WRITE_REQ, FILL, RESUME.
- IDLE:
  - `memRead` && !`hit`: `stall`=1 in the same cycle; latch `addr`; go to READ_REQ.
  - Otherwise, `memWrite`: `stall`=1; latch `addr` and `writeData`; go to WRITE_REQ.
  - `memRead` takes priority when both are set; the store is dropped and not counted.
  - Read hit or no access: `stall`=0; remain in IDLE.
- READ_REQ: `memReq`=1, `memWe`=0, `stall`=1.
  - On `memAck`: latch `memRData` into `fillData` and go to FILL.
- WRITE_REQ: `memReq`=1, `memWe`=1, `stall`=1.
  - On `memAck`: go to RESUME.
- FILL: `cacheFill`=1 for exactly one cycle, `stall`=1; go to RESUME.
- RESUME: `stall`=0 for exactly one cycle, so the pipeline advances on this edge. The FSM does not re-evaluate `memRead`/`memWrite`/`hit` in this state; it always returns to IDLE. This prevents a store from retriggering.
- Timeout:
  - The wait counter clears on entry to each REQ state and increments each REQ cycle without `memAck`.
  - When the count reaches `TIMEOUT`: set `memError`, drop `memReq`, go to RESUME with `bubble`=1.
  - `memError` is cleared only by `reset`.
- `memAck` outside REQ states is ignored.
- Counters:
  - `missCount` increments on READ_REQ→FILL.
  - `writeCount` increments on WRITE_REQ→RESUME.
  - `stallCycles` increments every cycle `stall`=1.
  - All counters saturate at 2^CNT_W−1; there is no wrap.
- `memAddr`, `memWData`, `fillData` hold their values until the next latch.

## Timing
- Reset values (next posedge with `reset`=1): state IDLE; `memReq`, `memWe`, `cacheFill`, `bubble`, `memError` = 0; `memAddr`, `memWData`, `fillData` = 0; all counters = 0.
- `stall` is 0 during reset, apart from the combinational IDLE detect.
- Reset mid-transaction: `memReq` drops on the next edge; the in-flight `memAck` is ignored.
- Read miss, n ≥ 1 cycles in READ_REQ (ack on the n-th): `stall` high for 2+n cycles (detect, n REQ, FILL), then RESUME. Minimum 3 stall cycles.
- Store, n cycles in WRITE_REQ: `stall` high for 1+n cycles. Minimum 2 stall cycles.
- `memReq` stays high continuously from REQ entry until the ack edge; it never glitches low while waiting.
- Back-to-back accesses: an access present in the cycle after RESUME is detected normally from IDLE.

## Test plan
- Read hit stream (`memRead`=1, `hit`=1, 10 cycles) -> `stall`=0 throughout; counters stay 0; `memReq` never asserted.
- Read miss at `addr`=0x00000040, `memAck` 4 cycles after `memReq` rises with `memRData`=0xDEADBEEF -> `stall` high 6 cycles; one-cycle `cacheFill` with `fillData`=0xDEADBEEF, `memAddr`=0x40; `missCount`=1; `stallCycles`=6.
- Store 0x12345678 to 0x80 with immediate ack -> `memWe`=1, `memWData`=0x12345678, 2 stall cycles; `writeCount`=1; no retrigger in RESUME.
- `memAck` withheld with `TIMEOUT`=8 -> `memReq` drops after 8 REQ cycles; `memError`=1 and stays set; `bubble`=1 for one cycle; `missCount` unchanged.
- `reset` pulsed while in READ_REQ -> state IDLE; `memReq`=0 and all counters 0 next cycle; a late `memAck` causes no `cacheFill`.
- `memRead`=1 with `hit`=0 and `memWrite`=1 together -> read path only; `writeCount` stays 0.
